watch_set_editor: RTL and testbench
===================================

# watch_set_editor

Interactive time/date set-mode editor for the watch. It snapshots the running BCD time on entry and lets the user move a cursor across six fields, incrementing or decrementing each with calendar-correct wrap. Only the selected field blinks on the 16x2 character display. On commit it issues a one-cycle load pulse with the edited time. It sits between the debounced switch inputs, the timekeeping counter (its load port) and the LCD character driver (index in, ASCII out).

## Interface
Parameters:
- BLINK_DIV, 25_000_000: clk cycles per blink half-period; minimum 2.
- YEAR_HI, 8'h20: BCD century shown before the two-digit year.
- LEAP_EN, 1: 1 gives 29 days in February when year%4==0; 0 gives February a fixed 28 days.

Ports:
- clk  in  1  system clock; one clock domain for the whole block.
- rst  in  1  synchronous, active-high reset.
- active  in  1  set mode selected; low means IDLE (live display, no editing).
- sw_in  in  4  debounced, clk-synchronous buttons: [0] next field, [1] increment, [2] decrement, [3] commit.
- year, month, day, hour, minute, second  in  8 each  live BCD time from the timekeeper.
- index  in  5  LCD character position, 0–15 line 1, 16–31 line 2.
- out  out  8  ASCII character for index.
- bin_time  out  48  edited time: {year, month, day, hour, minute, second}, BCD.
- en_time  out  1  one-cycle load strobe; bin_time is valid in the same cycle.

## Operation
- States:
  - IDLE → EDIT on a rising edge of active. On entry, snapshot all six inputs into edit registers and set cursor=0 (year).
  - EDIT → IDLE when active goes low. No commit is made, and edits are discarded.
- Cursor order: year(0) → month(1) → day(2) → hour(3) → minute(4) → second(5) → year. Each rising edge of sw_in[0] advances one step.
- Button events are rising edges of sw_in bits, detected against a registered copy. They act only in EDIT.
- Same-cycle priority: commit > next > inc > dec. Only the highest-priority event acts in a cycle; the others are dropped.
- Field ranges:
  - year 00–99
  - month 01–12
  - day 01–dim(year, month)
  - hour 00–23
  - minute 00–59
  - second 00–59
- Wrap: inc at max gives min; dec at min gives max. All arithmetic is BCD; the low nibble carries at 9.
- Day clamp: if a month or year change makes day > dim, day is set to dim in the same update (e.g. 31 → 30 for Apr; 29 → 28 for Feb of a non-leap year).
- Snapshot values out of range (non-BCD or >max) are forced to the field min on the first inc/dec of that field.
- Commit: bin_time ← edit registers and en_time=1 for exactly one cycle. The block stays in EDIT with cursor unchanged.
- Blink: a free-running counter toggles blink every BLINK_DIV cycles. In EDIT, the selected field's digit positions show 8'h20 while blink=0. Labels and other fields are always shown. In IDLE, nothing blinks and live inputs are displayed.
- Display map (ASCII digits = 8'h30 + nibble):
  - Line 1:
    - 0–2 "SET"; shows spaces in IDLE
    - 3–4 space
    - 5–6 YEAR_HI digits (part of the year field)
    - 7–8 year
    - 9 'Y'
    - 10–11 month
    - 12 'M'
    - 13–14 day
    - 15 'D'
  - Line 2:
    - 16–19 "TIME"
    - 20 space
    - 21–22 hour
    - 23 'H'
    - 24–25 minute
    - 26 'M'
    - 27–28 second
    - 29 'S'
    - 30–31 space

## Timing
- Reset values:
  - state IDLE, cursor=0, blink=1, blink counter=0
  - edit registers=0, bin_time=48'h0, en_time=0
  - out=8'h20, edge registers=0
- A button edge seen in cycle t updates the field register at the end of cycle t. The new value is reflected on out from cycle t+2 for a static index.
- out is registered with latency 1 from index and from the field registers.
- en_time is high in cycle t+1 for a commit edge in cycle t.
- A held button produces one action only; there is no auto-repeat.
- rst asserted mid-edit returns to IDLE in the next cycle. en_time is forced to 0 even if a commit edge coincides with rst.
- active low while a commit edge arrives: no commit, because IDLE ignores buttons.

## Structure
- Package watch_pkg holds:
  - field index constants (FLD_YEAR..FLD_SEC)
  - ASCII constants (CH_SPACE, CH_0, label letters)
  - function dim(year, month, leap_en) returning BCD days-in-month
  - per-field BCD min/max constants
- Sub-module bcd_field_step: combinational one-field stepper with inputs value, min, max and inc/dec, and output value with BCD wrap.
- The top level owns the FSM, edge detect, blink counter, day clamp and display mux.

## Test plan
- Reset, then active=1 with live time 8'h24,8'h02,8'h29,8'h23,8'h59,8'h58 → edit registers snapshot; index 7,8 give out 8'h32,8'h34.
- Cursor on day=29, year 24; step year to 25 with sw_in[1] → year 25, day clamped to 28. Then month inc → 03, day stays 28.
- Cursor on hour=23, inc → 00; dec → 23. Minute 00, dec → 59.
- Commit (sw_in[3]) → en_time high for exactly 1 cycle; bin_time == edit registers. Held commit gives no second pulse.
- Next and inc edges in the same cycle → cursor advances, field unchanged. Commit and rst in the same cycle → en_time stays 0, state IDLE.
- BLINK_DIV=4: the selected field's positions alternate digit/8'h20 every 4 cycles; other fields are constant; in IDLE nothing blinks.

Source files
------------

// File: rtl/watch_pkg.sv
// watch_pkg: field indices, ASCII codes, BCD field limits and calendar helpers for the set editor.
package watch_pkg;
  localparam logic [2:0] FLD_YEAR = 3'd0, FLD_MON = 3'd1, FLD_DAY = 3'd2;
  localparam logic [2:0] FLD_HOUR = 3'd3, FLD_MIN = 3'd4, FLD_SEC = 3'd5, FLD_NONE = 3'd7;
  localparam logic [7:0] CH_SPACE = 8'h20, CH_0 = 8'h30, CH_S = 8'h53, CH_E = 8'h45, CH_T = 8'h54;
  localparam logic [7:0] CH_I = 8'h49, CH_M = 8'h4D, CH_Y = 8'h59, CH_D = 8'h44, CH_H = 8'h48;
  localparam logic [7:0] YEAR_MIN = 8'h00, YEAR_MAX = 8'h99, MON_MIN = 8'h01, MON_MAX = 8'h12;
  localparam logic [7:0] DAY_MIN = 8'h01, HOUR_MIN = 8'h00, HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MIN = 8'h00, MIN_MAX = 8'h59, SEC_MIN = 8'h00, SEC_MAX = 8'h59;

  // 10*hi + lo is divisible by 4 exactly when 2*hi[0] + lo is
  function automatic logic [7:0] dim(input logic [7:0] year, input logic [7:0] month, input logic leap_en);
    logic [4:0] t;
    t = {3'b000, year[4], 1'b0} + {1'b0, year[3:0]};
    return (month == 8'h02) ? ((leap_en && t[1:0] == 2'b00) ? 8'h29 : 8'h28) :
           (month == 8'h04 || month == 8'h06 || month == 8'h09 || month == 8'h11) ? 8'h30 : 8'h31;
  endfunction

  function automatic logic [7:0] fld_min(input logic [2:0] f);
    return (f == FLD_YEAR) ? YEAR_MIN : (f == FLD_MON) ? MON_MIN : (f == FLD_DAY) ? DAY_MIN :
           (f == FLD_HOUR) ? HOUR_MIN : (f == FLD_MIN) ? MIN_MIN : SEC_MIN;
  endfunction

  function automatic logic [7:0] fld_max(input logic [2:0] f, input logic [7:0] day_max);
    return (f == FLD_YEAR) ? YEAR_MAX : (f == FLD_MON) ? MON_MAX : (f == FLD_DAY) ? day_max :
           (f == FLD_HOUR) ? HOUR_MAX : (f == FLD_MIN) ? MIN_MAX : SEC_MAX;
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] n);
    return CH_0 + {4'h0, n};
  endfunction
endpackage

// File: rtl/watch_set_editor_if.sv
// watch_set_editor_if: switches, live time, LCD index/char and load port of the set editor.
interface watch_set_editor_if;
  logic        active;
  logic [3:0]  sw_in;
  logic [7:0]  year, month, day, hour, minute, second;
  logic [4:0]  index;
  logic [7:0]  out;
  logic [47:0] bin_time;
  logic        en_time;
  modport master (output active, sw_in, year, month, day, hour, minute, second, index,
                  input out, bin_time, en_time);
  modport slave (input active, sw_in, year, month, day, hour, minute, second, index,
                 output out, bin_time, en_time);
endinterface

// File: rtl/bcd_field_step.sv
// bcd_field_step: one BCD field incremented or decremented with wrap; out-of-range values snap to min.
module bcd_field_step (
  input  logic [7:0] value,
  input  logic [7:0] min,
  input  logic [7:0] max,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] result
);
  logic valid;
  always_comb begin
    valid = value[3:0] <= 4'd9 && value[7:4] <= 4'd9 && value >= min && value <= max;
    result = !(inc || dec) ? value : !valid ? min :
             inc ? ((value == max) ? min : (value[3:0] == 4'd9) ? {value[7:4] + 4'd1, 4'd0} : value + 8'd1) :
                   ((value == min) ? max : (value[3:0] == 4'd0) ? {value[7:4] - 4'd1, 4'd9} : value - 8'd1);
  end
endmodule

// File: rtl/watch_set_editor.sv
// watch_set_editor: set-mode time/date editor with blinking cursor field, LCD character mux and load strobe.
module watch_set_editor import watch_pkg::*; #(
  parameter int          BLINK_DIV = 25_000_000,
  parameter logic [7:0]  YEAR_HI   = 8'h20,
  parameter bit          LEAP_EN   = 1'b1
) (
  input logic clk,
  input logic rst,
  watch_set_editor_if.slave bus
);
  typedef enum logic {IDLE, EDIT} state_t;
  localparam int BW = $clog2(BLINK_DIV);

  state_t state, state_n;
  logic active_q, edit, act, inc, dec, blink;
  logic [3:0] sw_q, ev;
  logic [2:0] cursor, fld;
  logic [7:0] ed [6], ed_n [6], live [6], v [6];
  logic [7:0] stepped, ch, out_n;
  logic [BW-1:0] bcnt;

  assign ev = bus.sw_in & ~sw_q;
  assign edit = state == EDIT;
  assign act = edit && bus.active;
  assign inc = act && ev[1] && !ev[0] && !ev[3];
  assign dec = act && ev[2] && !ev[1] && !ev[0] && !ev[3];

  always_comb begin
    state_n = (state == IDLE && bus.active && !active_q) ? EDIT :
              (state == EDIT && !bus.active) ? IDLE : state;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  bcd_field_step u_step (
    .value (ed[cursor]),
    .min   (fld_min(cursor)),
    .max   (fld_max(cursor, dim(ed[FLD_YEAR], ed[FLD_MON], LEAP_EN))),
    .inc   (inc),
    .dec   (dec),
    .result(stepped)
  );

  // a year or month step may shorten the month under the current day
  always_comb begin
    ed_n = ed;
    ed_n[cursor] = stepped;
    ed_n[FLD_DAY] = (cursor <= FLD_MON && ed_n[FLD_DAY] > dim(ed_n[FLD_YEAR], ed_n[FLD_MON], LEAP_EN)) ?
                    dim(ed_n[FLD_YEAR], ed_n[FLD_MON], LEAP_EN) : ed_n[FLD_DAY];
  end

  always_comb begin
    live = '{bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second};
    for (int i = 0; i < 6; i++) v[i] = edit ? ed[i] : live[i];
  end

  always_comb begin
    {fld, ch} = {FLD_NONE, CH_SPACE};
    case (bus.index)
      5'd0:  ch = edit ? CH_S : CH_SPACE;
      5'd1:  ch = edit ? CH_E : CH_SPACE;
      5'd2:  ch = edit ? CH_T : CH_SPACE;
      5'd5:  {fld, ch} = {FLD_YEAR, asc(YEAR_HI[7:4])};
      5'd6:  {fld, ch} = {FLD_YEAR, asc(YEAR_HI[3:0])};
      5'd7:  {fld, ch} = {FLD_YEAR, asc(v[0][7:4])};
      5'd8:  {fld, ch} = {FLD_YEAR, asc(v[0][3:0])};
      5'd9:  ch = CH_Y;
      5'd10: {fld, ch} = {FLD_MON, asc(v[1][7:4])};
      5'd11: {fld, ch} = {FLD_MON, asc(v[1][3:0])};
      5'd12: ch = CH_M;
      5'd13: {fld, ch} = {FLD_DAY, asc(v[2][7:4])};
      5'd14: {fld, ch} = {FLD_DAY, asc(v[2][3:0])};
      5'd15: ch = CH_D;
      5'd16: ch = CH_T;
      5'd17: ch = CH_I;
      5'd18: ch = CH_M;
      5'd19: ch = CH_E;
      5'd21: {fld, ch} = {FLD_HOUR, asc(v[3][7:4])};
      5'd22: {fld, ch} = {FLD_HOUR, asc(v[3][3:0])};
      5'd23: ch = CH_H;
      5'd24: {fld, ch} = {FLD_MIN, asc(v[4][7:4])};
      5'd25: {fld, ch} = {FLD_MIN, asc(v[4][3:0])};
      5'd26: ch = CH_M;
      5'd27: {fld, ch} = {FLD_SEC, asc(v[5][7:4])};
      5'd28: {fld, ch} = {FLD_SEC, asc(v[5][3:0])};
      5'd29: ch = CH_S;
      default: ;
    endcase
    out_n = (edit && !blink && fld == cursor) ? CH_SPACE : ch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sw_q <= 4'h0;
      cursor <= FLD_YEAR;
      ed <= '{default: 8'h00};
      bus.bin_time <= 48'h0;
      bus.en_time <= 1'b0;
      bus.out <= CH_SPACE;
      bcnt <= '0;
      blink <= 1'b1;
    end else begin
      active_q <= bus.active;
      sw_q <= bus.sw_in;
      bus.out <= out_n;
      bcnt <= (bcnt == BW'(BLINK_DIV - 1)) ? '0 : bcnt + 1'b1;
      blink <= (bcnt == BW'(BLINK_DIV - 1)) ? ~blink : blink;
      bus.en_time <= act && ev[3];
      if (state == IDLE && state_n == EDIT) begin
        ed <= live;
        cursor <= FLD_YEAR;
      end else if (act && ev[3]) bus.bin_time <= {ed[0], ed[1], ed[2], ed[3], ed[4], ed[5]};
      else if (act && ev[0]) cursor <= (cursor == FLD_SEC) ? FLD_YEAR : cursor + 3'd1;
      else if (inc || dec) ed <= ed_n;
    end
  end
endmodule

// File: tb/tb_watch_set_editor.sv
// tb_watch_set_editor: directed checks of snapshot, stepping, clamp, commit, blink and reset behaviour.
module tb_watch_set_editor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  watch_set_editor_if bus ();
  watch_set_editor #(.BLINK_DIV(4), .YEAR_HI(8'h20), .LEAP_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b);
    bus.sw_in = b;
    tick();
    bus.sw_in = 4'h0;
    tick();
  endtask

  task automatic set_live(input logic [47:0] t);
    {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second} = t;
  endtask

  task automatic commit(input string tag, input logic [47:0] exp);
    bus.sw_in = 4'h8;
    tick();
    check({tag, " strobe"}, 48'(bus.en_time), 48'h1);
    check(tag, bus.bin_time, exp);
    bus.sw_in = 4'h0;
    tick();
    check({tag, " strobe end"}, 48'(bus.en_time), 48'h0);
  endtask

  task automatic sample(input logic [4:0] idx, output int digits, output int spaces, output logic [7:0] last);
    digits = 0;
    spaces = 0;
    last = 8'h00;
    bus.index = idx;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (bus.out == 8'h20) spaces++;
      else begin
        digits++;
        last = bus.out;
      end
      tick();
    end
  endtask

  task automatic check_pos(input string tag, input logic [4:0] idx, input logic [7:0] ch, input int shown);
    int d, s;
    logic [7:0] c;
    sample(idx, d, s, c);
    check({tag, " char"}, 48'(c), 48'(ch));
    check({tag, " shown"}, 48'(d), 48'(shown));
  endtask

  initial begin
    int d, s;
    logic [7:0] c;
    bus.active = 1'b0;
    bus.sw_in = 4'h0;
    bus.index = 5'd0;
    set_live(48'h24_02_29_23_59_58);
    tick(3);
    check("reset out", 48'(bus.out), 48'h20);
    check("reset en_time", 48'(bus.en_time), 48'h0);
    check("reset bin_time", bus.bin_time, 48'h0);
    rst = 1'b0;
    tick();
    bus.active = 1'b1;
    tick(2);
    set_live(48'h99_02_29_23_59_58);
    check_pos("snap year hi", 5'd7, 8'h32, 4);
    check_pos("snap year lo", 5'd8, 8'h34, 4);
    check_pos("century", 5'd5, 8'h32, 4);
    check_pos("month steady", 5'd10, 8'h30, 8);
    check_pos("label S", 5'd0, 8'h53, 8);
    commit("snapshot", 48'h24_02_29_23_59_58);
    press(4'h2);
    commit("year inc clamp", 48'h25_02_28_23_59_58);
    press(4'h1); press(4'h2);
    commit("month inc", 48'h25_03_28_23_59_58);
    press(4'h1); press(4'h1); press(4'h2);
    commit("hour wrap up", 48'h25_03_28_00_59_58);
    press(4'h4);
    commit("hour wrap down", 48'h25_03_28_23_59_58);
    press(4'h1); press(4'h2);
    commit("min wrap up", 48'h25_03_28_23_00_58);
    press(4'h4);
    commit("min wrap down", 48'h25_03_28_23_59_58);
    press(4'h3);
    commit("next beats inc", 48'h25_03_28_23_59_58);
    check_pos("sec blinks", 5'd27, 8'h35, 4);
    check_pos("min steady", 5'd24, 8'h35, 8);
    press(4'h2);
    commit("sec inc", 48'h25_03_28_23_59_59);
    press(4'h2);
    commit("sec wrap", 48'h25_03_28_23_59_00);
    press(4'h1); press(4'h2);
    commit("cursor wrap", 48'h26_03_28_23_59_00);
    press(4'h6);
    commit("inc beats dec", 48'h27_03_28_23_59_00);
    bus.sw_in = 4'h8;
    tick();
    check("held commit first", 48'(bus.en_time), 48'h1);
    tick();
    check("held commit 2", 48'(bus.en_time), 48'h0);
    tick();
    check("held commit 3", 48'(bus.en_time), 48'h0);
    bus.sw_in = 4'h0;
    tick();
    bus.active = 1'b0;
    tick(2);
    check_pos("idle sec", 5'd28, 8'h38, 8);
    check_pos("idle year", 5'd7, 8'h39, 8);
    sample(5'd0, d, s, c);
    check("idle label blank", 48'(s), 48'd8);
    set_live(48'h99_02_29_3A_59_58);
    bus.active = 1'b1;
    tick(2);
    commit("resnap", 48'h99_02_29_3A_59_58);
    press(4'h1); press(4'h1); press(4'h1); press(4'h2);
    commit("bad hour to min", 48'h99_02_29_00_59_58);
    bus.active = 1'b0;
    bus.sw_in = 4'h8;
    tick();
    check("commit on exit", 48'(bus.en_time), 48'h0);
    check("bin kept on exit", bus.bin_time, 48'h99_02_29_00_59_58);
    bus.sw_in = 4'h0;
    tick();
    bus.active = 1'b1;
    tick(2);
    bus.sw_in = 4'h8;
    rst = 1'b1;
    tick();
    check("commit with rst", 48'(bus.en_time), 48'h0);
    check("bin after rst", bus.bin_time, 48'h0);
    rst = 1'b0;
    bus.sw_in = 4'h0;
    tick(2);
    commit("edits discarded", 48'h99_02_29_3A_59_58);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
